uart_rx_deser: RTL and testbench

//   UART receive deserializer. Converts the asynchronous serial line into bytes
//   and presents them on a valid/ready byte interface to the echo/buffer stage.
//   It oversamples at FCLK, checks the start and stop bits, and flags framing

---
 rtl/uart_rx_deser.sv | 132 +++++++++++++
 tb/tb_uart_rx_deser.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 2-FF input synchronizer, mid-bit sampling FSM,
// valid/ready byte output with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx_deser #(
  parameter int FCLK      = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int BIT_CNT = FCLK / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT + 1);
  localparam int IW      = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           sync_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
  logic                 rx_s;
  logic                 good_stop;

  assign rx_s      = sync_reg[1];
  assign good_stop = (state_reg == STOP) && (cnt_reg == CNT_LAST) && rx_s;

  // Preset to idle-high so reset release does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], rx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (cnt_reg == CNT_MID) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= DATA;
              idx_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (idx_reg == IDX_LAST) state_reg <= STOP;
            else                     idx_reg   <= idx_reg + 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= BRK;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BRK: begin
          // Hold off until the line returns high so a break cannot retrigger.
          if (rx_s) state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase

      if (good_stop) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg  <= shift_reg;
          rx_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: directed frames, expected bytes queued at stimulus
// time and popped by a monitor on each accepted transfer.
`timescale 1ns/1ps
module tb_uart_rx_deser;
  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_deser #(
    .FCLK(1000000),
    .BAUD(100000),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Inputs change 2 ns after a rising edge; outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic accept_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: got %02h, expected no transfer", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("xfer data=%02h expected=%02h", rx_data, e);
          check("xfer_data", {24'd0, rx_data}, {24'd0, e});
        end
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err || overrun) check("flag_exclusive", {31'd0, frame_err && overrun}, 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);

    // 1: 0xA5 held with rx_ready low
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(3);
    check("t1_valid", {31'd0, rx_valid}, 32'd1);
    check("t1_data", {24'd0, rx_data}, 32'h A5);
    tick(20);
    check("t1_hold_valid", {31'd0, rx_valid}, 32'd1);
    check("t1_hold_data", {24'd0, rx_data}, 32'hA5);
    check("t1_ferr", fe_cnt, 0);
    check("t1_ovr", ov_cnt, 0);
    accept_one();
    check("t1_released", {31'd0, rx_valid}, 32'd0);

    // 2: short glitch rejected
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    check("t2_valid", {31'd0, rx_valid}, 32'd0);
    check("t2_ferr", fe_cnt, 0);

    // 3: bad stop, line held low, then released
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(30);
    check("t3_ferr_pulse", fe_cnt, 1);
    check("t3_valid", {31'd0, rx_valid}, 32'd0);
    rx = 1'b1;
    tick(120);
    check("t3_no_retrigger", {31'd0, rx_valid}, 32'd0);
    check("t3_ferr_once", fe_cnt, 1);

    // 4: overrun on second byte
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(3);
    check("t4_valid", {31'd0, rx_valid}, 32'd1);
    check("t4_data", {24'd0, rx_data}, 32'h11);
    check("t4_ovr", ov_cnt, 1);
    accept_one();

    // 5: back-to-back with rx_ready high
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    check("t5_drained", exp_q.size(), 0);
    check("t5_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_last_data", {24'd0, rx_data}, 32'hFF);
    rx_ready = 1'b0;

    // 6: async reset during data bit 4
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    check("t6_rst_data", {24'd0, rx_data}, 32'd0);
    check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    tick(2);
    rst = 1'b0;
    rx = 1'b1;
    tick(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(3);
    check("t6_valid", {31'd0, rx_valid}, 32'd1);
    check("t6_data", {24'd0, rx_data}, 32'h5A);
    accept_one();
    tick(5);
    check("end_queue", exp_q.size(), 0);
    check("end_ferr", fe_cnt, 1);
    check("end_ovr", ov_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
